// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// The multicycle CPU has one word-addressed unified memory. Two ports share
// it: the instruction-fetch port, which only reads, and the data port, which
// reads and writes. This block picks which port is served next, using a
// round-robin choice when both ask at once. It runs the chosen access
// through a three-state sequencer (IDLE -> ACCESS -> RESP).
//
// The memory writes on every clock edge while its write enable is high.
// For that reason mem_write is a single-cycle strobe, placed in the last
// ACCESS cycle. Read data is registered per port and returned together with
// a one-cycle acknowledge in RESP.
//
// Ports:
//   clk, rst        clock (rising edge); reset, asynchronous, active-high
//   i_req, i_adr    instruction fetch request (level) and word address
//   i_ack, i_rdata  one-cycle fetch acknowledge, registered fetch data
//   d_req, d_we     data request (level); 1 = write, 0 = read
//   d_adr, d_wdata  data address and write data
//   d_ack, d_rdata  one-cycle data acknowledge, registered load data
//   mem_adr         memory address (holds its last value between accesses)
//   mem_wdata       memory write data (holds its last value between accesses)
//   mem_read        memory read enable, high during every read ACCESS cycle
//   mem_write       memory write strobe, high in the final write ACCESS cycle
//   mem_rdata       memory read data, combinational from mem_adr
//   busy            sequencer is not IDLE
//   conflict_cnt    saturating count of IDLE cycles with both requests high
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ACCESS_LAT = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_adr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // The wait counter steps through 0 .. ACCESS_LAT-1 while in ACCESS.
    localparam int WAIT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(ACCESS_LAT - 1);
    // This is the cycle before the final one. The write strobe is registered
    // at this point, so it appears exactly in the final ACCESS cycle.
    localparam logic [WAIT_W-1:0] WAIT_PENULT = WAIT_W'((ACCESS_LAT >= 2) ? (ACCESS_LAT - 2) : 0);
    // With a single-cycle access, the final cycle is the first cycle. The
    // write strobe must therefore be set at the moment of the grant.
    localparam logic              LAT_ONE     = (ACCESS_LAT == 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_t              r_state;
    logic                r_last_d;      // 1 = data port won the latest grant
    logic                r_win_d;       // port being served: 1 = data port
    logic                r_we;          // served access is a write
    logic [WAIT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]   r_adr;         // latched address, drives mem_adr
    logic [DATA_W-1:0]   r_wdata;       // latched write data, drives mem_wdata
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_i_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic [CNT_W-1:0]    r_conflict;

    // Arbitration decision, only consumed while IDLE.
    logic                w_any_req;
    logic                w_tie;
    logic                w_pick_d;
    logic [ADDR_W-1:0]   w_sel_adr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_we;
    logic                w_wait_last;

    assign w_any_req   = i_req | d_req;
    assign w_tie       = i_req & d_req;
    // On a tie the port that did not win last time is served. Otherwise the
    // only requester is served.
    assign w_pick_d    = w_tie ? ~r_last_d : d_req;
    assign w_sel_adr   = w_pick_d ? d_adr : i_adr;
    assign w_sel_wdata = w_pick_d ? d_wdata : '0;
    assign w_sel_we    = w_pick_d & d_we;
    assign w_wait_last = (r_wait == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b1;    // the instruction port wins the first tie
            r_win_d     <= 1'b0;
            r_we        <= 1'b0;
            r_wait      <= '0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_conflict  <= '0;
        end else begin
            // Acknowledges are single-cycle pulses unless set below.
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_win_d     <= w_pick_d;
                        r_last_d    <= w_pick_d;
                        r_we        <= w_sel_we;
                        r_adr       <= w_sel_adr;
                        r_wdata     <= w_sel_wdata;
                        r_wait      <= '0;
                        r_mem_read  <= ~w_sel_we;
                        r_mem_write <= w_sel_we & LAT_ONE;
                        r_state     <= ST_ACCESS;
                        if (w_tie && (r_conflict != CNT_MAX)) begin
                            r_conflict <= r_conflict + 1'b1;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (w_wait_last) begin
                        // Final ACCESS cycle: the address has been stable
                        // for the whole access, so mem_rdata is valid now.
                        if (!r_we) begin
                            if (r_win_d) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_d_ack     <= r_win_d;
                        r_i_ack     <= ~r_win_d;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait      <= r_wait + 1'b1;
                        r_mem_write <= r_we & (r_wait == WAIT_PENULT);
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack        = r_i_ack;
    assign i_rdata      = r_i_rdata;
    assign d_ack        = r_d_ack;
    assign d_rdata      = r_d_rdata;
    assign mem_adr      = r_adr;
    assign mem_wdata    = r_wdata;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign busy         = (r_state != ST_IDLE);
    assign conflict_cnt = r_conflict;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    // Instance 0: ACCESS_LAT=1, CNT_W=16. Instance 1: ACCESS_LAT=3, CNT_W=2.
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        bit          port_d;
        bit          we;
        int          ack_cyc;
        logic [31:0] i_rd;
        logic [31:0] d_rd;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        i_req     [N];
    logic [31:0] i_adr     [N];
    logic        i_ack     [N];
    logic [31:0] i_rdata   [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [31:0] d_adr     [N];
    logic [31:0] d_wdata   [N];
    logic        d_ack     [N];
    logic [31:0] d_rdata   [N];
    logic [31:0] mem_adr   [N];
    logic [31:0] mem_wdata [N];
    logic        mem_read  [N];
    logic        mem_write [N];
    logic [31:0] mem_rdata [N];
    logic        busy      [N];
    logic [15:0] conflict_cnt [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [5:0] a);
        if (a == 6'd5) return 32'h8C22_0004;
        return ({26'h0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    // Memory seen by the DUTs: 64 words, written when mem_write is high.
    bit [31:0] phys_mem [N][64];
    bit [63:0] wr_flag  [N];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_write[k]) begin
                phys_mem[k][mem_adr[k][5:0]] <= mem_wdata[k];
                wr_flag[k][mem_adr[k][5:0]]  <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        localparam int CW  = (gi == 0) ? 16 : 2;
        logic [CW-1:0] w_cnt;

        mem_port_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .ACCESS_LAT(LAT), .CNT_W(CW)
        ) dut (
            .clk(clk), .rst(rst[gi]),
            .i_req(i_req[gi]), .i_adr(i_adr[gi]), .i_ack(i_ack[gi]), .i_rdata(i_rdata[gi]),
            .d_req(d_req[gi]), .d_we(d_we[gi]), .d_adr(d_adr[gi]), .d_wdata(d_wdata[gi]),
            .d_ack(d_ack[gi]), .d_rdata(d_rdata[gi]),
            .mem_adr(mem_adr[gi]), .mem_wdata(mem_wdata[gi]),
            .mem_read(mem_read[gi]), .mem_write(mem_write[gi]), .mem_rdata(mem_rdata[gi]),
            .busy(busy[gi]), .conflict_cnt(w_cnt)
        );

        assign conflict_cnt[gi] = 16'(w_cnt);
        assign mem_rdata[gi] = wr_flag[gi][mem_adr[gi][5:0]] ? phys_mem[gi][mem_adr[gi][5:0]]
                                                            : init_word(mem_adr[gi][5:0]);
    end

    // Reference model state (per instance).
    logic [31:0] model_mem [N][64];
    bit          m_last_d  [N];
    int          m_cnt     [N];
    logic [31:0] m_last_i  [N];
    logic [31:0] m_last_dr [N];
    int          m_writes  [N];
    int          m_reads   [N];
    int          seen_wr   [N];
    int          seen_rd   [N];
    int          last_wr_cyc [N];

    exp_t sbq0[$];
    exp_t sbq1[$];
    op_t  op_i[$];
    op_t  op_d[$];

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
        end
    endtask

    function automatic void sb_push(input int k, input exp_t e);
        if (k == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endfunction

    function automatic bit sb_pop(input int k, output exp_t e);
        e = '{default: 0};
        if (k == 0) begin
            if (sbq0.size() == 0) return 1'b0;
            e = sbq0.pop_front();
        end else begin
            if (sbq1.size() == 0) return 1'b0;
            e = sbq1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic int sb_size(input int k);
        return (k == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic void model_reset(input int k);
        m_last_d[k]  = 1'b1;
        m_cnt[k]     = 0;
        m_last_i[k]  = '0;
        m_last_dr[k] = '0;
    endfunction

    task automatic add_i(input logic [31:0] adr);
        op_t o;
        o.adr = adr; o.we = 1'b0; o.wdata = '0;
        op_i.push_back(o);
    endtask

    task automatic add_d(input logic [31:0] adr, input logic we, input logic [31:0] wdata);
        op_t o;
        o.adr = adr; o.we = we; o.wdata = wdata;
        op_d.push_back(o);
    endtask

    // Monitor: pops one expected response for every acknowledge.
    initial begin
        exp_t e;
        bit   got;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!rst[k]) begin
                    if (mem_write[k]) begin
                        seen_wr[k]++;
                        last_wr_cyc[k] = cyc;
                    end
                    if (mem_read[k]) seen_rd[k]++;
                    if (mem_read[k] && mem_write[k]) chk("rd_wr_overlap", k, 64'(1), 64'(0));
                    if (i_ack[k] && d_ack[k]) begin
                        chk("ack_overlap", k, 64'(1), 64'(0));
                    end else if (i_ack[k] || d_ack[k]) begin
                        got = sb_pop(k, e);
                        if (!got) begin
                            chk("unexpected_ack", k, 64'(1), 64'(0));
                        end else begin
                            chk("ack_port", k, 64'(d_ack[k]), 64'(e.port_d));
                            chk("ack_cycle", k, 64'(cyc), 64'(e.ack_cyc));
                            chk("i_rdata", k, 64'(i_rdata[k]), 64'(e.i_rd));
                            chk("d_rdata", k, 64'(d_rdata[k]), 64'(e.d_rd));
                            chk("conflict_cnt", k, 64'(conflict_cnt[k]), 64'(e.cnt));
                            if (e.port_d && e.we)
                                chk("write_strobe_cycle", k, 64'(last_wr_cyc[k]), 64'(e.ack_cyc - 1));
                        end
                        $display("ack dut%0d port=%s cyc=%0d i_rdata=0x%08h d_rdata=0x%08h cnt=%0d",
                                 k, d_ack[k] ? "D" : "I", cyc, i_rdata[k], d_rdata[k], conflict_cnt[k]);
                    end
                end
            end
        end
    end

    // Issues every queued operand on both ports of instance k. The ports
    // hold their requests until acknowledged. The model predicts the grant
    // order from the round-robin rule and pushes the expected responses.
    task automatic run_batch(input int k);
        op_t  qi[$];
        op_t  qd[$];
        op_t  o;
        exp_t e;
        int   n_i, n_d, n, start, ri, rd, xi, xd, left_i, left_d, bound;
        bit   pick_d;
        qi = op_i; qd = op_d;
        op_i.delete(); op_d.delete();
        n_i = qi.size(); n_d = qd.size(); n = n_i + n_d;
        if (n == 0) return;
        @(negedge clk);
        start = cyc;
        if (n_i > 0) begin
            i_req[k] = 1'b1; i_adr[k] = qi[0].adr;
        end
        if (n_d > 0) begin
            d_req[k] = 1'b1; d_adr[k] = qd[0].adr; d_we[k] = qd[0].we; d_wdata[k] = qd[0].wdata;
        end
        ri = n_i; rd = n_d; xi = 0; xd = 0;
        for (int j = 0; j < n; j++) begin
            if (ri > 0 && rd > 0) begin
                pick_d = !m_last_d[k];
                if (m_cnt[k] < cmax_of(k)) m_cnt[k] = m_cnt[k] + 1;
            end else begin
                pick_d = (rd > 0);
            end
            m_last_d[k] = pick_d;
            e.port_d = pick_d;
            e.we     = 1'b0;
            if (pick_d) begin
                o = qd[xd]; xd++; rd--;
                e.we = o.we;
                if (o.we) begin
                    model_mem[k][o.adr[5:0]] = o.wdata;
                    m_writes[k]++;
                end else begin
                    m_last_dr[k] = model_mem[k][o.adr[5:0]];
                    m_reads[k]++;
                end
            end else begin
                o = qi[xi]; xi++; ri--;
                m_last_i[k] = model_mem[k][o.adr[5:0]];
                m_reads[k]++;
            end
            e.ack_cyc = start + (j + 1) * (lat_of(k) + 2) - 1;
            e.i_rd    = m_last_i[k];
            e.d_rd    = m_last_dr[k];
            e.cnt     = 16'(m_cnt[k]);
            sb_push(k, e);
        end
        left_i = n_i; left_d = n_d; xi = 1; xd = 1;
        bound  = (n + 1) * (lat_of(k) + 2) + 10;
        for (int t = 0; t < bound && (left_i + left_d) > 0; t++) begin
            @(negedge clk);
            if (i_ack[k] && left_i > 0) begin
                left_i--;
                if (xi < n_i) begin
                    i_adr[k] = qi[xi].adr; xi++;
                end else begin
                    i_req[k] = 1'b0;
                end
            end
            if (d_ack[k] && left_d > 0) begin
                left_d--;
                if (xd < n_d) begin
                    d_adr[k] = qd[xd].adr; d_we[k] = qd[xd].we; d_wdata[k] = qd[xd].wdata; xd++;
                end else begin
                    d_req[k] = 1'b0;
                end
            end
        end
        if ((left_i + left_d) > 0) begin
            chk("batch_timeout", k, 64'(left_i + left_d), 64'(0));
            i_req[k] = 1'b0; d_req[k] = 1'b0;
            if (k == 0) sbq0.delete(); else sbq1.delete();
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        chk({tag, "_i_ack"},     k, 64'(i_ack[k]), 64'(0));
        chk({tag, "_d_ack"},     k, 64'(d_ack[k]), 64'(0));
        chk({tag, "_mem_read"},  k, 64'(mem_read[k]), 64'(0));
        chk({tag, "_mem_write"}, k, 64'(mem_write[k]), 64'(0));
        chk({tag, "_busy"},      k, 64'(busy[k]), 64'(0));
        chk({tag, "_cnt"},       k, 64'(conflict_cnt[k]), 64'(0));
        chk({tag, "_i_rdata"},   k, 64'(i_rdata[k]), 64'(0));
        chk({tag, "_d_rdata"},   k, 64'(d_rdata[k]), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            i_req[k] = 1'b0; i_adr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_adr[k] = '0; d_wdata[k] = '0;
            for (int a = 0; a < 64; a++) model_mem[k][a] = init_word(6'(a));
            model_reset(k);
            m_writes[k] = 0; m_reads[k] = 0;
            seen_wr[k] = 0; seen_rd[k] = 0; last_wr_cyc[k] = -1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check_idle_outputs(k, "reset");
            chk("reset_mem_adr",   k, 64'(mem_adr[k]), 64'(0));
            chk("reset_mem_wdata", k, 64'(mem_wdata[k]), 64'(0));
            rst[k] = 1'b0;
        end

        // Tie from reset: I first, then D.
        add_i(32'd5); add_d(32'd7, 1'b0, '0); run_batch(0);
        // Both held for 8 transactions: I, D, I, D, ...
        for (int j = 0; j < 4; j++) begin
            add_i(32'($urandom_range(0, 63)));
            add_d(32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
        end
        run_batch(0);
        // Single fetch of word 5.
        add_i(32'd5); run_batch(0);

        // Write then read back on the ACCESS_LAT=3 instance.
        add_d(32'd10, 1'b1, 32'hDEAD_BEEF); run_batch(1);
        add_d(32'd10, 1'b0, '0); run_batch(1);

        // Reset during the second ACCESS cycle of a write.
        @(negedge clk);
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_adr[1] = 32'd10; d_wdata[1] = 32'h0BAD_F00D;
        @(negedge clk);
        chk("busy_in_access", 1, 64'(busy[1]), 64'(1));
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        d_req[1] = 1'b0; d_we[1] = 1'b0;
        check_idle_outputs(1, "midreset");
        #1;
        rst[1] = 1'b0;
        model_reset(1);
        repeat (4) @(negedge clk);
        chk("post_reset_busy", 1, 64'(busy[1]), 64'(0));
        // Next tie goes to I. The aborted write must not have landed.
        add_i(32'($urandom_range(0, 63))); add_d(32'd10, 1'b0, '0); run_batch(1);
        // Repeated ties saturate the 2-bit counter.
        for (int j = 0; j < 3; j++) begin
            add_i(32'($urandom_range(0, 63)));
            add_d(32'($urandom_range(0, 15)), 1'b0, '0);
        end
        run_batch(1);

        // Randomised rounds on both instances.
        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            if (sel != 2) for (int j = 0; j < $urandom_range(1, 2); j++) add_i(32'($urandom_range(0, 63)));
            if (sel != 1) for (int j = 0; j < $urandom_range(1, 2); j++)
                add_d(32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
            run_batch(r % 2);
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("scoreboard_empty", k, 64'(sb_size(k)), 64'(0));
            chk("write_strobes",    k, 64'(seen_wr[k]), 64'(m_writes[k]));
            chk("read_cycles",      k, 64'(seen_rd[k]), 64'(m_reads[k] * lat_of(k)));
            chk("final_busy",       k, 64'(busy[k]), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single word-addressed unified memory between the instruction-fetch port (read-only) and the data port (read/write) of the multicycle CPU.
- Arbitrates with round-robin priority and sequences each access through a small FSM.
- Produces a one-cycle write strobe toward the memory, since the memory writes on every clock edge while its write enable is high.
- Returns registered read data plus a one-cycle acknowledge to the winning requester.

Parameters:
- ADDR_W, 32, address width; word address, passed straight to the memory.
- DATA_W, 32, data word width.
- ACCESS_LAT, 1, cycles the memory address and controls are held per access; legal values ≥ 1.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction-port request (level).
- i_adr  in  ADDR_W  instruction fetch address.
- i_ack  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_W  registered fetch data.
- d_req  in  1  data-port request (level).
- d_we  in  1  1 = write, 0 = read; sampled with d_req.
- d_adr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle pulse: data access complete, d_rdata valid on reads.
- d_rdata  out  DATA_W  registered load data.
- mem_adr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data; combinational from mem_adr.
- busy  out  1  high when FSM is not IDLE.
- conflict_cnt  out  CNT_W  count of IDLE cycles with i_req and d_req both high; saturating.

Behaviour:
- Reset (async) values:
  - FSM = IDLE; all outputs = 0.
  - last_grant = DATA, so the instruction port wins the first tie.
  - Latched address/data/we = 0; wait counter = 0.
  - Reset mid-access drops mem_write and mem_read immediately; no ack is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port opposite last_grant, then increment conflict_cnt (holds at 2^CNT_W−1).
  - On grant: latch winner id, address, write data, and we (we = 0 for the instruction port). Clear the wait counter, go to ACCESS, set last_grant = winner.
- ACCESS (lasts exactly ACCESS_LAT cycles):
  - mem_adr = latched address; mem_wdata = latched data.
  - mem_read = ~we for every ACCESS cycle.
  - mem_write = we only in the final ACCESS cycle (wait counter == ACCESS_LAT−1), giving exactly one write edge.
  - In the final cycle, read accesses capture mem_rdata into the winner's rdata register; then go to RESP.
  - Request inputs are ignored during ACCESS.
- RESP (one cycle):
  - Winner's ack = 1; mem_read = mem_write = 0.
  - Go to IDLE.
  - The other port's rdata is unchanged.
  - For writes, d_rdata keeps its previous value.
- Outside ACCESS: mem_adr and mem_wdata hold their last values; mem_read = mem_write = 0.
- Latency: a request seen in IDLE at cycle 0 gets its ack at cycle ACCESS_LAT+1. Minimum transaction period is ACCESS_LAT+2 cycles.
- Request hold rule: requesters hold req and operands stable until ack. A req still high in the cycle after ack is a new transaction. With both ports continuously requesting, grants strictly alternate I, D, I, D…
- rdata registers hold until the next read ack to the same port.
- busy = (state != IDLE).

Test Plan:
- Single instruction read, ACCESS_LAT=1, memory word 5 = 0x8C220004, i_adr=5:
  - i_ack at cycle 2, i_rdata = 0x8C220004, mem_write never high.
- Data write, d_we=1, d_adr=10, d_wdata=0xDEADBEEF, ACCESS_LAT=3:
  - mem_write high only in cycle 3; d_ack in cycle 4.
  - A follow-up read of address 10 returns 0xDEADBEEF.
- i_req and d_req raised together from reset:
  - Instruction port granted first, conflict_cnt = 1.
  - Data port is granted next, in the following IDLE cycle.
- Both reqs held high for 8 transactions:
  - Grant order I, D, I, D, I, D, I, D; acks never coincide.
  - conflict_cnt increments on each tie.
- rst pulsed during the second ACCESS cycle of a write (ACCESS_LAT=3):
  - mem_write never asserts; no ack; FSM returns to IDLE.
  - Next tie goes to the instruction port.
- CNT_W=2, 5 consecutive tie arbitrations:
  - conflict_cnt saturates at 3.
